// File: rtl/m_eventually_mon.sv
// Per-channel req -> ack -> done window monitor: flags late or missing handshakes,
// keeps sticky per-channel error flags and saturating aggregate result counters.
module m_eventually_mon #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ACK_MIN  = 1,
  parameter int unsigned ACK_MAX  = 2,
  parameter int unsigned DONE_MIN = 1,
  parameter int unsigned DONE_MAX = 2,
  parameter int unsigned STRONG   = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   ack,
  input  logic [N_CH-1:0]   done,
  input  logic              err_clr,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   pass_p,
  output logic [N_CH-1:0]   vac_p,
  output logic [N_CH-1:0]   fail_p,
  output logic [N_CH-1:0]   ack_err,
  output logic [N_CH-1:0]   done_err,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  vac_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitDone} state_e;

  localparam logic [7:0] AckMin  = 8'(ACK_MIN);
  localparam logic [7:0] AckMax  = 8'(ACK_MAX);
  localparam logic [7:0] DoneMin = 8'(DONE_MIN);
  localparam logic [7:0] DoneMax = 8'(DONE_MAX);

  logic [N_CH-1:0] req_prev_q, ack_prev_q;
  logic [N_CH-1:0] req_rose, ack_rose;
  logic [N_CH-1:0] pass_d, vac_d, fail_d;
  logic [N_CH-1:0] pass_q, vac_q, fail_q;
  logic [N_CH-1:0] ack_err_set, done_err_set;
  logic [N_CH-1:0] ack_err_q, done_err_q;
  logic [CNT_W-1:0] pass_cnt_q, vac_cnt_q, fail_cnt_q;

  assign req_rose = req & ~req_prev_q;
  assign ack_rose = ack & ~ack_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_q <= '0;
      ack_prev_q <= '0;
    end else begin
      req_prev_q <= req;
      ack_prev_q <= ack;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e     state_q, state_d;
    logic [7:0] k_q, k_d;
    logic       pass_c, vac_c, fail_c, aerr_c, derr_c;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        k_q     <= 8'd0;
      end else begin
        state_q <= state_d;
        k_q     <= k_d;
      end
    end

    always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pass_c  = 1'b0;
      vac_c   = 1'b0;
      fail_c  = 1'b0;
      aerr_c  = 1'b0;
      derr_c  = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_rose[c]) begin
            state_d = StWaitAck;
            k_d     = 8'd1;
          end
        end
        StWaitAck: begin
          // Leaving at AckMax bounds k, so only the lower limit needs checking.
          if (ack_rose[c] && (k_q >= AckMin)) begin
            state_d = StWaitDone;
            k_d     = 8'd1;
          end else if (k_q >= AckMax) begin
            state_d = StIdle;
            k_d     = 8'd0;
            if (STRONG != 0) begin
              fail_c = 1'b1;
              aerr_c = 1'b1;
            end else begin
              vac_c = 1'b1;
            end
          end else begin
            k_d = k_q + 8'd1;
          end
        end
        StWaitDone: begin
          if (done[c] && (k_q >= DoneMin)) begin
            state_d = StIdle;
            k_d     = 8'd0;
            pass_c  = 1'b1;
          end else if (k_q >= DoneMax) begin
            state_d = StIdle;
            k_d     = 8'd0;
            fail_c  = 1'b1;
            derr_c  = 1'b1;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
        default: begin
          state_d = StIdle;
          k_d     = 8'd0;
        end
      endcase
    end

    assign busy[c]         = (state_q != StIdle);
    assign pass_d[c]       = pass_c;
    assign vac_d[c]        = vac_c;
    assign fail_d[c]       = fail_c;
    assign ack_err_set[c]  = aerr_c;
    assign done_err_set[c] = derr_c;
  end

  function automatic logic [4:0] popcnt(input logic [N_CH-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < N_CH; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [4:0]       inc);
    logic [CNT_W+4:0] sum;
    sum = {5'd0, cnt} + {{CNT_W{1'b0}}, inc};
    if (sum > {5'd0, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  // Counters accumulate the next-state pulses so they update on the same edge as the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q     <= '0;
      vac_q      <= '0;
      fail_q     <= '0;
      ack_err_q  <= '0;
      done_err_q <= '0;
      pass_cnt_q <= '0;
      vac_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_q     <= pass_d;
      vac_q      <= vac_d;
      fail_q     <= fail_d;
      ack_err_q  <= (ack_err_q & ~{N_CH{err_clr}}) | ack_err_set;
      done_err_q <= (done_err_q & ~{N_CH{err_clr}}) | done_err_set;
      pass_cnt_q <= sat_add(pass_cnt_q, popcnt(pass_d));
      vac_cnt_q  <= sat_add(vac_cnt_q, popcnt(vac_d));
      fail_cnt_q <= sat_add(fail_cnt_q, popcnt(fail_d));
    end
  end

  assign pass_p   = pass_q;
  assign vac_p    = vac_q;
  assign fail_p   = fail_q;
  assign ack_err  = ack_err_q;
  assign done_err = done_err_q;
  assign pass_cnt = pass_cnt_q;
  assign vac_cnt  = vac_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule
